// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner.
// Combinational helpers only; no state, no flow control.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;

    localparam logic [ROWS-1:0] ROW_IDLE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_HELD,
        ST_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_t;

    function automatic logic [2:0] hit_count(input logic [COLS-1:0] p);
        hit_count = {2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]};
    endfunction

    // Lowest pressed column wins when a row reports several hits.
    function automatic logic [1:0] first_col(input logic [COLS-1:0] p);
        first_col = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (p[i]) first_col = 2'(i);
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with synchronous reset value.
// Latency: 2 cycles. No backpressure.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad reader with frame-level debounce; one key_valid pulse per confirmed press.
// Latency: up to (DEBOUNCE_FRAMES+1)*4*SCAN_DIV+3 cycles press-to-pulse. No backpressure; pulses are fire-and-forget.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic                  clk_10000Hz,
    input  logic                  reset,
    input  logic [COLS-1:0]       key_col_n,
    output logic [ROWS-1:0]       key_row_n,
    output logic                  key_valid,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_held
);

    localparam int              DW         = $clog2(SCAN_DIV);
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX    = 4'(DEBOUNCE_FRAMES);

    logic [DW-1:0]         dwell_q, dwell_d;
    logic [1:0]            row_idx_q, row_idx_d;
    logic [ROWS-1:0]       key_row_n_q, key_row_n_d;
    logic [1:0]            acc_cnt_q, acc_cnt_d;
    logic [KEY_CODE_W-1:0] acc_code_q, acc_code_d;
    logic                  frame_done_q, frame_done_d;
    state_t                state_q, state_d;
    logic [KEY_CODE_W-1:0] cand_q, cand_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  key_valid_q, key_valid_d;
    logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
    logic                  key_held_q, key_held_d;

    logic [COLS-1:0]       col_s;
    logic [COLS-1:0]       pressed;
    logic [2:0]            hits;
    logic [2:0]            hit_sum;
    logic                  sample_en;
    frame_t                frame_res;

    sync_2ff #(
        .WIDTH   (COLS),
        .RST_VAL (ROW_IDLE)
    ) u_col_sync (
        .clk   (clk_10000Hz),
        .reset (reset),
        .d     (key_col_n),
        .q     (col_s)
    );

    assign sample_en = (dwell_q == DWELL_LAST);
    assign pressed   = ~col_s;
    assign hits      = hit_count(pressed);
    assign hit_sum   = {1'b0, acc_cnt_q} + hits;

    always_comb begin
        dwell_d   = dwell_q + DW'(1);
        row_idx_d = row_idx_q;
        if (sample_en) begin
            dwell_d   = '0;
            row_idx_d = row_idx_q + 2'd1;
        end
        key_row_n_d = ~(4'b0001 << row_idx_d);
    end

    // Accumulators clear in the evaluation cycle; no sample can land there since dwell is 0.
    always_comb begin
        acc_cnt_d    = acc_cnt_q;
        acc_code_d   = acc_code_q;
        frame_done_d = 1'b0;
        if (frame_done_q) begin
            acc_cnt_d  = '0;
            acc_code_d = '0;
        end else if (sample_en) begin
            if (acc_cnt_q == 2'd0 && hits != 3'd0) begin
                acc_code_d = {row_idx_q, first_col(pressed)};
            end
            acc_cnt_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
            frame_done_d = (row_idx_q == 2'd3);
        end
    end

    always_comb begin
        case (acc_cnt_q)
            2'd0:    frame_res = FR_NONE;
            2'd1:    frame_res = FR_SINGLE;
            default: frame_res = FR_MULTI;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        if (frame_done_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_res == FR_SINGLE) begin
                        state_d = ST_CONFIRM;
                        cand_d  = acc_code_q;
                        cnt_d   = 4'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (frame_res == FR_SINGLE && acc_code_q == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_MAX) begin
                            state_d     = ST_HELD;
                            cnt_d       = '0;
                            key_valid_d = 1'b1;
                            key_code_d  = cand_q;
                            key_held_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (frame_res == FR_SINGLE) begin
                        cand_d = acc_code_q;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_HELD: begin
                    if (frame_res == FR_NONE) begin
                        state_d = ST_RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                ST_RELEASE: begin
                    if (frame_res == FR_NONE) begin
                        if (cnt_q + 4'd1 == DEB_MAX) begin
                            state_d    = ST_IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_10000Hz) begin
        if (reset) begin
            dwell_q      <= '0;
            row_idx_q    <= '0;
            key_row_n_q  <= 4'b1110;
            acc_cnt_q    <= '0;
            acc_code_q   <= '0;
            frame_done_q <= 1'b0;
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            cnt_q        <= '0;
            key_valid_q  <= 1'b0;
            key_code_q   <= '0;
            key_held_q   <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            row_idx_q    <= row_idx_d;
            key_row_n_q  <= key_row_n_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_code_q   <= acc_code_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            key_valid_q  <= key_valid_d;
            key_code_q   <= key_code_d;
            key_held_q   <= key_held_d;
        end
    end

    assign key_row_n = key_row_n_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=3, 16-cycle frames).
// A behavioural keypad pulls a column low only while its row is driven.
module tb_keypad_scanner;

    logic       clk_10000Hz = 1'b0;
    logic       reset       = 1'b1;
    logic [3:0] key_col_n;
    logic [3:0] key_row_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    logic [15:0] keys = 16'h0000;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          pulse_cnt = 0;
    int          pulse_cyc = -1;
    logic [3:0]  pulse_code = 4'h0;
    int          drops;
    logic [3:0]  exp_row;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk_10000Hz (clk_10000Hz),
        .reset       (reset),
        .key_col_n   (key_col_n),
        .key_row_n   (key_row_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_held    (key_held)
    );

    always #5 clk_10000Hz = ~clk_10000Hz;

    // Key index r*4+c sits at row r, column c; its code is therefore the index itself.
    always_comb begin
        key_col_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && key_row_n[r] == 1'b0) key_col_n[c] = 1'b0;
            end
        end
    end

    always @(negedge clk_10000Hz) begin
        if (key_valid === 1'b1) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_cyc  = cyc;
            pulse_code = key_code;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_10000Hz);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc        = 0;
        pulse_cnt  = 0;
        pulse_cyc  = -1;
        pulse_code = 4'h0;
    endtask

    initial begin
        // Idle scan after reset
        keys = 16'h0000;
        do_reset();
        check("rst_row", key_row_n, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'h0);
        check("rst_held", key_held, 1'b0);
        for (int i = 1; i < 32; i++) begin
            tick();
            exp_row = 4'b1111;
            exp_row[(cyc / 4) % 4] = 1'b0;
            check("scan_row", key_row_n, exp_row);
        end
        run_to(100);
        check("idle_pulses", pulse_cnt, 0);
        check("idle_held", key_held, 1'b0);

        // Row 2 / col 1 held for 10 frames
        keys = 16'h0200;
        do_reset();
        run_to(48);
        check("k9_code_pre", key_code, 4'h0);
        check("k9_held_pre", key_held, 1'b0);
        run_to(49);
        check("k9_valid", key_valid, 1'b1);
        check("k9_code", key_code, 4'h9);
        drops = 0;
        while (cyc < 160) begin
            tick();
            if (key_held !== 1'b1) drops++;
        end
        check("k9_held_drops", drops, 0);
        check("k9_pulses", pulse_cnt, 1);
        check("k9_pulse_cyc", pulse_cyc, 49);
        check("k9_pulse_code", pulse_code, 4'h9);

        // Key 5: one frame on, one off, then held
        keys = 16'h0020;
        do_reset();
        run_to(16);
        keys = 16'h0000;
        run_to(32);
        keys = 16'h0020;
        run_to(80);
        check("k5_no_early", pulse_cnt, 0);
        check("k5_held_pre", key_held, 1'b0);
        run_to(90);
        check("k5_pulses", pulse_cnt, 1);
        check("k5_pulse_cyc", pulse_cyc, 81);
        check("k5_pulse_code", pulse_code, 4'h5);
        check("k5_held", key_held, 1'b1);

        // Keys 0 and 3 together: ghosting must never confirm
        keys = 16'h0009;
        do_reset();
        run_to(100);
        check("multi_pulses", pulse_cnt, 0);
        check("multi_held", key_held, 1'b0);
        check("multi_code", key_code, 4'h0);

        // Key A confirmed, one-frame release glitch, then a real release
        keys = 16'h0400;
        do_reset();
        run_to(64);
        keys = 16'h0000;
        run_to(80);
        keys = 16'h0400;
        run_to(90);
        check("kA_held_glitch", key_held, 1'b1);
        run_to(112);
        keys = 16'h0000;
        run_to(160);
        check("kA_held_last", key_held, 1'b1);
        run_to(161);
        check("kA_held_drop", key_held, 1'b0);
        run_to(200);
        check("kA_pulses", pulse_cnt, 1);
        check("kA_pulse_cyc", pulse_cyc, 49);
        check("kA_pulse_code", pulse_code, 4'hA);

        // Reset while HELD with the key still down
        keys = 16'h0400;
        do_reset();
        run_to(60);
        check("mid_held_before", key_held, 1'b1);
        check("mid_code_before", key_code, 4'hA);
        reset = 1'b1;
        tick();
        check("mid_rst_row", key_row_n, 4'b1110);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_held", key_held, 1'b0);
        do_reset();
        run_to(48);
        check("mid_no_early", pulse_cnt, 0);
        run_to(60);
        check("mid_pulses", pulse_cnt, 1);
        check("mid_pulse_cyc", pulse_cyc, 49);
        check("mid_pulse_code", pulse_code, 4'hA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
